accumulator: RTL and testbench

// - Running-sum accumulator: adds a signed WIDTH-bit input sample to an internal total on each enabled clock.
// - Building block for datapath integrators, event counters and checksum-style sums.
// - Single clock domain, registered outputs, no handshake beyond a per-cycle enable.

---
 rtl/accumulator.sv | 52 +++++
 tb/tb_accumulator.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/accumulator.sv
// Signed running-sum accumulator with a sticky overflow flag.
// Define ACC_SATURATE_EN to clamp on overflow; by default the total wraps modulo 2^WIDTH.
module accumulator #(
   parameter int WIDTH = 32
) (
   input  logic             i_CLK,
   input  logic             i_RESET,
   input  logic             i_ENABLE,
   input  logic             i_CLEAR,
   input  logic [WIDTH-1:0] i_DATA_IN,
   output logic [WIDTH-1:0] o_TOTAL,
   output logic             o_OVF
);

   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] r_total;
   logic             r_ovf;
   logic [WIDTH-1:0] w_sum;
   logic             w_ovf;
   logic [WIDTH-1:0] w_next_total;

   assign w_sum = r_total + i_DATA_IN;

   // Signed overflow: like-signed operands producing a result of the other sign.
   assign w_ovf = (r_total[WIDTH-1] == i_DATA_IN[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != r_total[WIDTH-1]);

`ifdef ACC_SATURATE_EN
   assign w_next_total = w_ovf ? (r_total[WIDTH-1] ? MIN_NEG : MAX_POS) : w_sum;
`else
   assign w_next_total = w_sum;
`endif

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         r_total <= '0;
         r_ovf   <= 1'b0;
      end else if (i_CLEAR) begin
         r_total <= '0;
         r_ovf   <= 1'b0;
      end else if (i_ENABLE) begin
         r_total <= w_next_total;
         r_ovf   <= r_ovf | w_ovf;
      end
   end

   assign o_TOTAL = r_total;
   assign o_OVF   = r_ovf;

endmodule

// File: tb/tb_accumulator.sv
// Table-driven bench for accumulator, with a few hand-written multi-cycle sequences.
// Expected values follow ACC_SATURATE_EN when it is defined for the build.
module tb_accumulator;

   logic        clk;
   logic        rst;
   logic        en;
   logic        clr;
   logic [31:0] din;
   logic [31:0] total;
   logic        ovf;

   int checks;
   int errors;

   accumulator #(.WIDTH(32)) dut (
      .i_CLK     (clk),
      .i_RESET   (rst),
      .i_ENABLE  (en),
      .i_CLEAR   (clr),
      .i_DATA_IN (din),
      .o_TOTAL   (total),
      .o_OVF     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef ACC_SATURATE_EN
   localparam logic [31:0] E_POS1 = 32'h7FFF_FFFF;
   localparam logic [31:0] E_POS2 = 32'h7FFF_FFFF;
   localparam logic [31:0] E_NEG  = 32'h8000_0000;
`else
   localparam logic [31:0] E_POS1 = 32'h8000_0000;
   localparam logic [31:0] E_POS2 = 32'h8000_0001;
   localparam logic [31:0] E_NEG  = 32'h7FFF_FFFF;
`endif

   typedef struct {
      logic        rst;
      logic        clr;
      logic        en;
      logic [31:0] data;
      logic [31:0] exp_total;
      logic        exp_ovf;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vecs [NVEC];

   task automatic check_total(input string name, input logic [31:0] exp);
      checks++;
      if (total !== exp) begin
         errors++;
         $display("FAIL %s: o_TOTAL=0x%08h expected 0x%08h", name, total, exp);
      end
   endtask

   task automatic check_ovf(input string name, input logic exp);
      checks++;
      if (ovf !== exp) begin
         errors++;
         $display("FAIL %s: o_OVF=%0b expected %0b", name, ovf, exp);
      end
   endtask

   task automatic step(input logic r, input logic c, input logic e, input logic [31:0] d);
      rst = r;
      clr = c;
      en  = e;
      din = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0; clr = 1'b0; en = 1'b0; din = '0;

      //           rst   clr   en    data           total          ovf
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000, 1'b0}; // reset with junk inputs
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h4000_0000, 32'h0000_0000, 1'b0}; // disabled: hold
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFE0, 32'hFFFF_FFE0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b0}; // carry-out, no overflow
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h4000_0000, E_POS1,        1'b1}; // positive overflow
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0001, E_POS2,        1'b1}; // flag sticky
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0005, E_POS2,        1'b1}; // hold keeps flag
      vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 1'b0}; // clear drops flag
      vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0005, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h0000_0007, 32'h0000_0000, 1'b0}; // clear beats enable
      vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0010, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0000, 1'b0}; // reset beats enable
      vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0003, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0};
      vecs[18] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, E_NEG,         1'b1}; // negative overflow

      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].rst, vecs[i].clr, vecs[i].en, vecs[i].data);
         $display("vec %0d: rst=%0b clr=%0b en=%0b data=0x%08h -> total=0x%08h ovf=%0b",
                  i, vecs[i].rst, vecs[i].clr, vecs[i].en, vecs[i].data, total, ovf);
         check_total($sformatf("vec%0d_total", i), vecs[i].exp_total);
         check_ovf($sformatf("vec%0d_ovf", i), vecs[i].exp_ovf);
      end

      // No combinational path: changing inputs between edges must not move the outputs.
      step(1'b0, 1'b1, 1'b0, 32'h0);
      rst = 1'b0; clr = 1'b0; en = 1'b1; din = 32'h0000_0100;
      #2;
      $display("comb: inputs changed mid-cycle -> total=0x%08h ovf=%0b", total, ovf);
      check_total("no_comb_path", 32'h0000_0000);
      @(posedge clk);
      #1;
      $display("comb: after edge -> total=0x%08h", total);
      check_total("one_cycle_latency", 32'h0000_0100);

      // Running sum 1..10 on top of 0x100.
      begin
         logic [31:0] model;
         model = 32'h0000_0100;
         for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 1'b1, 32'(k));
            model = model + 32'(k);
            $display("sum: add %0d -> total=0x%08h", k, total);
            check_total($sformatf("sum_step%0d", k), model);
         end
         check_ovf("sum_no_ovf", 1'b0);
      end

      // Reset mid-stream, then accumulation restarts from zero.
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
      $display("restart: add -2 after reset -> total=0x%08h ovf=%0b", total, ovf);
      check_total("restart_total", 32'hFFFF_FFFE);
      check_ovf("restart_ovf", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
